// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture block.
// Segment order is {a,b,c,d,e,f,g}, with 1 meaning the segment is lit.
package seg7_pkg;

  localparam int NUM_DIG = 4;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to value decoder.
// Define SEG7_HEX_EN to also accept the glyphs A, b, C, d, E and F.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] val,
  output logic       invalid
);

  always_comb begin
    val     = 4'h0;
    invalid = 1'b0;
    unique case (pat)
      SEG_0:   val = 4'h0;
      SEG_1:   val = 4'h1;
      SEG_2:   val = 4'h2;
      SEG_3:   val = 4'h3;
      SEG_4:   val = 4'h4;
      SEG_5:   val = 4'h5;
      SEG_6:   val = 4'h6;
      SEG_7:   val = 4'h7;
      SEG_8:   val = 4'h8;
      SEG_9:   val = 4'h9;
`ifdef SEG7_HEX_EN
      SEG_A:   val = 4'hA;
      SEG_B:   val = 4'hB;
      SEG_C:   val = 4'hC;
      SEG_D:   val = 4'hD;
      SEG_E:   val = 4'hE;
      SEG_F:   val = 4'hF;
`endif
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_to_bcd_capture.sv
// Captures the digits of a scanned 4-digit seven-segment display into a BCD frame.
// Define SEG7_HEX_EN to accept hex glyphs A-F as well as 0-9.
module seg7_to_bcd_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_sel,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_bcd,
  output logic        err_pat,
  output logic        overrun
);

  localparam logic [7:0] STB = 8'(STABLE_CYC);

  state_t              state, st_n;
  logic [7:0]          cnt, cnt_n;
  logic [10:0]         smp, cur;
  logic [NUM_DIG-1:0]  mask, mask_n;
  logic [15:0]         slots, slots_n;
  logic                onehot, cap;
  logic [1:0]          idx;
  logic [3:0]          dec_val;
  logic                dec_inv;

  assign cur    = {seg, dig_sel};
  assign onehot = $onehot(dig_sel);
  assign idx    = {dig_sel[3] | dig_sel[2], dig_sel[3] | dig_sel[1]};

  seg7_pattern_decode u_dec (
    .pat     (seg),
    .val     (dec_val),
    .invalid (dec_inv)
  );

  always_comb begin
    st_n  = state;
    cnt_n = cnt;
    cap   = 1'b0;
    if (state == ST_IDLE) begin
      if (onehot) begin
        st_n  = ST_SETTLE;
        cnt_n = 8'd1;
      end
    end else if (cur != smp) begin
      st_n  = onehot ? ST_SETTLE : ST_IDLE;
      cnt_n = onehot ? 8'd1 : 8'd0;
    end else if (state == ST_SETTLE) begin
      cnt_n = 8'(cnt + 8'd1);
    end
    // A window of one edge captures on the very edge that starts it
    if (st_n == ST_SETTLE && cnt_n == STB) begin
      cap  = 1'b1;
      st_n = ST_HOLD;
    end
  end

  always_comb begin
    mask_n  = mask;
    slots_n = slots;
    if (cap && !dec_inv) begin
      slots_n[idx*4 +: 4] = dec_val;
      mask_n[idx]         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      smp       <= '0;
      mask      <= '0;
      slots     <= '0;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      err_pat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state   <= st_n;
      cnt     <= cnt_n;
      smp     <= cur;
      slots   <= slots_n;
      err_pat <= cap && dec_inv;
      overrun <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (&mask_n) begin
        mask <= '0;
        if (!out_valid || out_ready) begin
          out_bcd   <= slots_n;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        mask <= mask_n;
      end
    end
  end

endmodule

// File: tb/tb_seg7_to_bcd_capture.sv
// Directed bench for seg7_to_bcd_capture with STABLE_CYC = 4.
// Build with SEG7_HEX_EN defined to exercise the hex glyph decode.
module tb_seg7_to_bcd_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_bcd;
  logic        err_pat;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int err_cnt, ovr_cnt, acc_cnt, vcyc;
  logic [15:0] last_bcd;

  logic [6:0] pat [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  always #5 clk = ~clk;

  seg7_to_bcd_capture #(.STABLE_CYC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bcd   (out_bcd),
    .err_pat   (err_pat),
    .overrun   (overrun)
  );

  always @(negedge clk) begin
    if (err_pat) err_cnt++;
    if (overrun) ovr_cnt++;
    if (out_valid) vcyc++;
    if (out_valid && out_ready) begin
      acc_cnt++;
      last_bcd = out_bcd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    err_cnt  = 0;
    ovr_cnt  = 0;
    acc_cnt  = 0;
    vcyc     = 0;
    last_bcd = '0;
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
    seg     = s;
    dig_sel = d;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic put(input int slot, input logic [6:0] s);
    drive(s, 4'(1 << slot), 4);
  endtask

  int exp_err, exp_acc;
  logic [15:0] exp_hex;

  initial begin
    clr();
    rst_n     = 1'b0;
    seg       = '0;
    dig_sel   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_bcd", 32'(out_bcd), 0);
    chk("rst_err", 32'(err_pat), 0);
    chk("rst_ovr", 32'(overrun), 0);
    rst_n = 1'b1;

    // basic frame 4321
    clr();
    put(0, pat[1]);
    put(1, pat[2]);
    put(2, pat[3]);
    put(3, pat[4]);
    drive(7'h0, 4'h0, 3);
    chk("f1_acc", 32'(acc_cnt), 1);
    chk("f1_bcd", 32'(last_bcd), 32'h4321);
    chk("f1_pulse", 32'(vcyc), 1);
    chk("f1_err", 32'(err_cnt), 0);

    // slot 2 held only 3 cycles
    clr();
    put(0, pat[5]);
    put(1, pat[6]);
    drive(pat[7], 4'b0100, 3);
    put(3, pat[8]);
    drive(7'h0, 4'h0, 3);
    chk("short_acc", 32'(acc_cnt), 0);
    put(2, pat[7]);
    drive(7'h0, 4'h0, 3);
    chk("short_fill", 32'(acc_cnt), 1);
    chk("short_bcd", 32'(last_bcd), 32'h8765);

    // undecodable pattern, held well past the window
    clr();
    drive(7'b0000001, 4'b0001, 8);
    drive(7'h0, 4'h0, 3);
    chk("bad_err", 32'(err_cnt), 1);
    chk("bad_valid", 32'(vcyc), 0);

    // back-pressure: second frame overruns
    clr();
    out_ready = 1'b0;
    put(0, pat[4]);
    put(1, pat[3]);
    put(2, pat[2]);
    put(3, pat[1]);
    put(0, pat[8]);
    put(1, pat[7]);
    put(2, pat[6]);
    put(3, pat[5]);
    drive(7'h0, 4'h0, 3);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_bcd", 32'(out_bcd), 32'h1234);
    chk("bp_ovr", 32'(ovr_cnt), 1);
    out_ready = 1'b1;
    drive(7'h0, 4'h0, 1);
    chk("bp_drain", 32'(out_valid), 0);
    chk("bp_keep", 32'(out_bcd), 32'h1234);

    // reset mid-frame
    clr();
    put(0, pat[7]);
    put(1, pat[8]);
    rst_n = 1'b0;
    drive(7'h0, 4'h0, 2);
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_bcd", 32'(out_bcd), 0);
    chk("mrst_err", 32'(err_pat), 0);
    chk("mrst_ovr", 32'(overrun), 0);
    rst_n = 1'b1;
    put(2, pat[0]);
    put(3, pat[9]);
    drive(7'h0, 4'h0, 3);
    chk("mrst_part", 32'(acc_cnt), 0);
    put(0, pat[7]);
    put(1, pat[8]);
    drive(7'h0, 4'h0, 3);
    chk("mrst_acc", 32'(acc_cnt), 1);
    chk("mrst_bcd2", 32'(last_bcd), 32'h9087);

    // hex glyph A on every slot
`ifdef SEG7_HEX_EN
    exp_err = 0;
    exp_acc = 1;
    exp_hex = 16'hAAAA;
`else
    exp_err = 4;
    exp_acc = 0;
    exp_hex = 16'h0000;
`endif
    clr();
    for (int k = 0; k < 4; k++) put(k, 7'b1110111);
    drive(7'h0, 4'h0, 3);
    chk("hex_err", 32'(err_cnt), 32'(exp_err));
    chk("hex_acc", 32'(acc_cnt), 32'(exp_acc));
    chk("hex_bcd", 32'(last_bcd), 32'(exp_hex));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
